// File: rtl/pci_io_initiator.sv
// Single-data-phase PCI initiator: REQn/GNTn arbitration, one address and one data phase, master/target abort.
// Define PCI_INIT_PARITY_EN to add PAR generation/checking and PERRn reporting (status 11).
module pci_io_initiator #(
    parameter int DEVSEL_TIMEOUT = 5,
    parameter int TRDY_TIMEOUT   = 16
) (
    input  logic        CLK,
    input  logic        RSTn,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic [3:0]  req_cmd,
    input  logic [3:0]  req_be,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [1:0]  resp_status,
    output logic [31:0] resp_rdata,
    output logic        REQn,
    input  logic        GNTn,
    inout  tri logic        FRAMEn,
    inout  tri logic        IRDYn,
    inout  tri logic [31:0] AD,
    inout  tri logic [3:0]  CBE,
    input  logic        TRDYn,
    input  logic        DEVSELn
`ifdef PCI_INIT_PARITY_EN
    ,
    inout  tri logic    PAR,
    input  logic        PERRn
`endif
);

    typedef enum logic [2:0] {IDLE, REQ, ADDR, DATA, TURN, PCHK} state_t;

    localparam logic [1:0] ST_OK   = 2'b00;
    localparam logic [1:0] ST_MA   = 2'b01;
    localparam logic [1:0] ST_TO   = 2'b10;
    localparam logic [1:0] ST_PERR = 2'b11;
    localparam logic [3:0] DEVSEL_LAST = 4'(DEVSEL_TIMEOUT - 1);
    localparam logic [7:0] TRDY_LAST   = 8'(TRDY_TIMEOUT - 1);

    state_t      state_reg, state_next;
    logic [31:0] addr_reg, wdata_reg, rdata_reg;
    logic [3:0]  cmd_reg, be_reg;
    logic [3:0]  wait_cnt_reg;
    logic [7:0]  trdy_cnt_reg;
    logic [1:0]  status_reg, status_next;
    logic        resp_valid_reg;
    logic [1:0]  resp_status_reg;
    logic        fire, capture_rd, accept, is_read;
    logic [1:0]  fire_status;

    assign is_read     = ~cmd_reg[0];
    assign req_ready   = (state_reg == IDLE) && !resp_valid_reg;
    assign accept      = req_valid && req_ready;
    assign resp_valid  = resp_valid_reg;
    assign resp_status = resp_status_reg;
    assign resp_rdata  = rdata_reg;
    assign REQn        = (state_reg != REQ);

    // Bus drivers are decoded straight from state so an async reset releases the bus at once.
    assign FRAMEn = (state_reg == ADDR) ? 1'b0 :
                    (state_reg == DATA || state_reg == TURN) ? 1'b1 : 1'bz;
    assign IRDYn  = (state_reg == DATA) ? 1'b0 :
                    (state_reg == ADDR || state_reg == TURN) ? 1'b1 : 1'bz;
    assign AD     = (state_reg == ADDR) ? addr_reg :
                    (state_reg == DATA && !is_read) ? wdata_reg : 32'bz;
    assign CBE    = (state_reg == ADDR) ? cmd_reg :
                    (state_reg == DATA) ? be_reg : 4'bz;
`ifdef PCI_INIT_PARITY_EN
    assign PAR    = (state_reg == DATA) ? ^{addr_reg, cmd_reg} :
                    (state_reg == TURN && !is_read) ? ^{wdata_reg, be_reg} : 1'bz;
`endif

    always_comb begin
        state_next  = state_reg;
        status_next = status_reg;
        fire        = 1'b0;
        fire_status = status_reg;
        capture_rd  = 1'b0;
        case (state_reg)
            IDLE: if (accept) state_next = REQ;
            REQ:  if (!GNTn && FRAMEn && IRDYn) state_next = ADDR;
            ADDR: state_next = DATA;
            DATA: begin
                if (!DEVSELn && !TRDYn) begin
                    status_next = ST_OK;
                    capture_rd  = is_read;
                    state_next  = TURN;
                end else if (DEVSELn && wait_cnt_reg == DEVSEL_LAST) begin
                    status_next = ST_MA;
                    state_next  = TURN;
                end else if (!DEVSELn && trdy_cnt_reg == TRDY_LAST) begin
                    status_next = ST_TO;
                    state_next  = TURN;
                end
            end
            TURN: begin
`ifdef PCI_INIT_PARITY_EN
                // Good writes wait one more clock so the target's PERRn can be seen.
                if (!is_read && status_reg == ST_OK) begin
                    state_next = PCHK;
                end else if (is_read && status_reg == ST_OK && (PAR != ^{rdata_reg, be_reg})) begin
                    status_next = ST_PERR;
                    state_next  = PCHK;
                end else begin
                    fire       = 1'b1;
                    state_next = IDLE;
                end
`else
                fire       = 1'b1;
                state_next = IDLE;
`endif
            end
`ifdef PCI_INIT_PARITY_EN
            PCHK: begin
                fire       = 1'b1;
                state_next = IDLE;
                if (!is_read && !PERRn) fire_status = ST_PERR;
            end
`endif
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_reg       <= IDLE;
            addr_reg        <= '0;
            wdata_reg       <= '0;
            rdata_reg       <= '0;
            cmd_reg         <= '0;
            be_reg          <= '0;
            wait_cnt_reg    <= '0;
            trdy_cnt_reg    <= '0;
            status_reg      <= ST_OK;
            resp_valid_reg  <= 1'b0;
            resp_status_reg <= ST_OK;
        end else begin
            state_reg      <= state_next;
            status_reg     <= status_next;
            resp_valid_reg <= fire;
            if (fire) resp_status_reg <= fire_status;
            if (accept) begin
                addr_reg  <= req_addr;
                cmd_reg   <= req_cmd;
                be_reg    <= req_be;
                wdata_reg <= req_wdata;
            end
            if (capture_rd) rdata_reg <= AD;
            if (state_reg == DATA) begin
                if (wait_cnt_reg != 4'hF) wait_cnt_reg <= wait_cnt_reg + 4'd1;
                if (!DEVSELn && TRDYn) trdy_cnt_reg <= trdy_cnt_reg + 8'd1;
            end else begin
                wait_cnt_reg <= '0;
                trdy_cnt_reg <= '0;
            end
        end
    end

endmodule

// File: tb/tb_pci_io_initiator.sv
// Bench for pci_io_initiator: per-transaction expected waveform built from the bus protocol rules,
// checked every clock by one compare process; directed plan cases followed by random transactions.
module tb_pci_io_initiator;

    localparam int DT    = 5;
    localparam int TT    = 16;
    localparam int NEVER = 1000;

    logic        CLK = 1'b0;
    logic        RSTn = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_addr = '0, req_wdata = '0;
    logic [3:0]  req_cmd = '0, req_be = '0;
    logic        resp_valid;
    logic [1:0]  resp_status;
    logic [31:0] resp_rdata;
    logic        REQn;
    logic        GNTn = 1'b1, TRDYn = 1'b1, DEVSELn = 1'b1;
    tri1         FRAMEn, IRDYn;
    tri1 [31:0]  AD;
    tri1 [3:0]   CBE;

    logic        fm_frame_oe = 1'b0, fm_irdy_oe = 1'b0, tg_ad_oe = 1'b0;
    logic [31:0] tg_ad = '0;
    assign FRAMEn = fm_frame_oe ? 1'b0 : 1'bz;
    assign IRDYn  = fm_irdy_oe ? 1'b0 : 1'bz;
    assign AD     = tg_ad_oe ? tg_ad : 32'bz;

    pci_io_initiator #(.DEVSEL_TIMEOUT(DT), .TRDY_TIMEOUT(TT)) dut (
        .CLK(CLK), .RSTn(RSTn),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_cmd(req_cmd),
        .req_be(req_be), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_status(resp_status), .resp_rdata(resp_rdata),
        .REQn(REQn), .GNTn(GNTn), .FRAMEn(FRAMEn), .IRDYn(IRDYn), .AD(AD), .CBE(CBE),
        .TRDYn(TRDYn), .DEVSELn(DEVSELn)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic        ready, reqn, frame, irdy, rv, chk_rd, led_cap;
        logic [31:0] ad, rd;
        logic [3:0]  cbe;
        logic [1:0]  st;
    } exp_t;

    exp_t exp_a[128];
    logic gnt_a[128], ffr_a[128], fir_a[128], dev_a[128], trdy_a[128], adoe_a[128];
    exp_t cur;
    int   cyc = 0;
    bit   active = 0;
    int   checks = 0, errors = 0;
    int   irdy_low_cnt = 0, resp_at = -1;
    logic led = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s (cycle %0d): got %08h, want %08h", nm, cyc, act, want);
        end
    endtask

    // Data-phase length and status from the timeout rules; d/t = DATA clock where DEVSELn/TRDYn drop.
    function automatic void data_phase(input int d, input int t, output int len, output logic [1:0] st);
        if (d >= DT)          begin len = DT;     st = 2'b01; end
        else if (t - d <= TT - 1) begin len = t + 1; st = 2'b00; end
        else                  begin len = d + TT; st = 2'b10; end
    endfunction

    always @(negedge CLK) begin
        if (active) begin
            cur = exp_a[cyc];
            chk("req_ready", req_ready, cur.ready);
            chk("REQn", REQn, cur.reqn);
            chk("FRAMEn", FRAMEn, cur.frame);
            chk("IRDYn", IRDYn, cur.irdy);
            chk("AD", AD, cur.ad);
            chk("CBE", CBE, cur.cbe);
            chk("resp_valid", resp_valid, cur.rv);
            if (cur.rv) chk("resp_status", resp_status, cur.st);
            if (cur.chk_rd) chk("resp_rdata", resp_rdata, cur.rd);
            if (cur.led_cap) led = AD[0];
            if (IRDYn === 1'b0) irdy_low_cnt++;
            if (resp_valid === 1'b1) resp_at = cyc;
        end
    end

    task automatic run_txn(input int p, input int g, input int busy, input logic [31:0] addr,
                           input logic [3:0] cmd, input logic [3:0] be, input logic [31:0] wdata,
                           input int d, input int t, input logic [31:0] rdata, input int rst_k);
        int len, a, n, mode;
        logic [1:0] st;
        logic rd;
        data_phase(d, t, len, st);
        rd = ~cmd[0];
        a  = p + g + 2;
        n  = p + g + 5 + len;
        irdy_low_cnt = 0;
        resp_at = -1;
        for (int c = 0; c < n; c++) begin
            exp_a[c].ready = (c <= p); exp_a[c].reqn = 1'b1; exp_a[c].frame = 1'b1;
            exp_a[c].irdy = 1'b1; exp_a[c].rv = 1'b0; exp_a[c].chk_rd = 1'b0; exp_a[c].led_cap = 1'b0;
            exp_a[c].ad = 32'hFFFF_FFFF; exp_a[c].rd = rdata; exp_a[c].cbe = 4'hF; exp_a[c].st = st;
            gnt_a[c] = 1'($urandom_range(0, 1)); ffr_a[c] = 1'b0; fir_a[c] = 1'b0;
            dev_a[c] = 1'b1; trdy_a[c] = 1'b1; adoe_a[c] = 1'b0;
        end
        for (int i = 0; i <= g; i++) begin
            int c = p + 1 + i;
            exp_a[c].reqn = 1'b0;
            if (i < g) begin
                mode = (busy >= 0) ? busy : int'($urandom_range(0, 3));
                gnt_a[c] = (mode == 0 || mode == 3);
                ffr_a[c] = (mode == 1 || mode == 3);
                fir_a[c] = (mode == 2);
                exp_a[c].frame = !ffr_a[c];
                exp_a[c].irdy  = !fir_a[c];
            end else begin
                gnt_a[c] = 1'b0;
            end
        end
        exp_a[a].frame = 1'b0; exp_a[a].ad = addr; exp_a[a].cbe = cmd;
        for (int k = 0; k < len; k++) begin
            int c = a + 1 + k;
            exp_a[c].irdy = 1'b0;
            exp_a[c].cbe  = be;
            exp_a[c].ad   = rd ? 32'hFFFF_FFFF : wdata;
            dev_a[c]  = (k >= d) ? 1'b0 : 1'b1;
            trdy_a[c] = (k >= d && k >= t) ? 1'b0 : 1'b1;
            if (k == len - 1 && st == 2'b00) begin
                if (rd) begin adoe_a[c] = 1'b1; exp_a[c].ad = rdata; end
                else if (addr == 32'h200 && cmd == 4'h3) exp_a[c].led_cap = 1'b1;
            end
        end
        exp_a[n-1].rv = 1'b1;
        exp_a[n-1].chk_rd = rd && (st == 2'b00);
        for (int c = 0; c < n; c++) begin
            @(posedge CLK); #1;
            req_valid = (c == p) || (c > p && $urandom_range(0, 1) == 1);
            if (c == p) begin
                req_addr = addr; req_cmd = cmd; req_be = be; req_wdata = wdata;
            end else begin
                req_addr = $urandom; req_cmd = 4'($urandom); req_be = 4'($urandom); req_wdata = $urandom;
            end
            if (c < p) req_valid = 1'b0;
            GNTn = gnt_a[c]; fm_frame_oe = ffr_a[c]; fm_irdy_oe = fir_a[c];
            DEVSELn = dev_a[c]; TRDYn = trdy_a[c]; tg_ad_oe = adoe_a[c]; tg_ad = rdata;
            cyc = c;
            active = 1;
            @(negedge CLK); #1;
            if (rst_k >= 0 && c == a + 1 + rst_k) begin
                RSTn = 1'b0;
                #1;
                active = 0;
                chk("rst_async_FRAMEn", FRAMEn, 1'b1);
                chk("rst_async_IRDYn", IRDYn, 1'b1);
                chk("rst_async_AD", AD, 32'hFFFF_FFFF);
                chk("rst_async_CBE", CBE, 4'hF);
                chk("rst_async_REQn", REQn, 1'b1);
                DEVSELn = 1'b1; TRDYn = 1'b1; req_valid = 1'b0;
                @(posedge CLK); #1;
                RSTn = 1'b1;
                repeat (3) begin
                    @(negedge CLK);
                    chk("rst_resp_valid", resp_valid, 1'b0);
                    chk("rst_req_ready", req_ready, 1'b1);
                    chk("rst_REQn", REQn, 1'b1);
                end
                return;
            end
        end
        active = 0;
        $display("txn addr=%08h cmd=%h be=%h wdata=%08h g=%0d d=%0d t=%0d len=%0d status=%0d", addr, cmd, be, wdata, g, d, t, len, st);
    endtask

    initial begin
        int p, g, d, t, sel;
        logic [3:0] cmd;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        chk("reset_req_ready", req_ready, 1'b1);
        chk("reset_REQn", REQn, 1'b1);
        chk("reset_resp_valid", resp_valid, 1'b0);
        chk("reset_resp_status", resp_status, 2'b00);
        chk("reset_resp_rdata", resp_rdata, 32'h0);
        chk("reset_FRAMEn", FRAMEn, 1'b1);
        chk("reset_AD", AD, 32'hFFFF_FFFF);
        chk("reset_CBE", CBE, 4'hF);
        RSTn = 1'b1;

        // 1: LED write, fast-decode target
        run_txn(0, 0, -1, 32'h200, 4'h3, 4'h0, 32'h1, 0, 0, 32'h0, -1);
        chk("t1_resp_at", resp_at, 5);
        chk("t1_irdy_low", irdy_low_cnt, 1);
        chk("t1_led", led, 1'b1);
        // 2: no target -> master abort
        run_txn(0, 0, -1, 32'h300, 4'h3, 4'h0, 32'h5, NEVER, NEVER, 32'h0, -1);
        chk("t2_irdy_low", irdy_low_cnt, 5);
        chk("t2_status", resp_status, 2'b01);
        // 3: read with 3 wait states
        run_txn(1, 0, -1, 32'h400, 4'h2, 4'h0, 32'h0, 0, 3, 32'hDEADBEEF, -1);
        chk("t3_irdy_low", irdy_low_cnt, 4);
        chk("t3_rdata", resp_rdata, 32'hDEADBEEF);
        chk("t3_status", resp_status, 2'b00);
        // 4: TRDYn never -> target timeout
        run_txn(0, 0, -1, 32'h500, 4'h7, 4'h3, 32'hA5A5A5A5, 0, NEVER, 32'h0, -1);
        chk("t4_irdy_low", irdy_low_cnt, 16);
        chk("t4_status", resp_status, 2'b10);
        // 5: ten clocks with no grant and a foreign master owning the bus
        run_txn(0, 10, 3, 32'h200, 4'h3, 4'h0, 32'h0, 0, 0, 32'h0, -1);
        chk("t5_resp_at", resp_at, 15);
        // 6: reset during DATA
        run_txn(0, 0, -1, 32'h600, 4'h3, 4'h0, 32'h12345678, NEVER, NEVER, 32'h0, 1);

        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 3))
                0: cmd = 4'h2;
                1: cmd = 4'h3;
                2: cmd = 4'h6;
                default: cmd = 4'h7;
            endcase
            p = $urandom_range(0, 2);
            g = $urandom_range(0, 3);
            sel = $urandom_range(0, 7);
            d = (sel <= 5) ? sel : NEVER;
            sel = $urandom_range(0, 7);
            if (d == NEVER || sel >= 6) t = NEVER;
            else if (sel == 4)          t = d + 15;
            else if (sel == 5)          t = d + 16;
            else                        t = d + sel;
            run_txn(p, g, -1, $urandom, cmd, 4'($urandom), $urandom, d, t, $urandom, -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pci_io_initiator.md
Name: pci_io_initiator

Overview:
Single-data-phase PCI bus initiator that turns local requests into PCI IO/memory read or write transactions. It sits upstream of the PCI IO-write target (LED register at 0x200) and drives FRAMEn, AD, CBE and IRDYn on the shared bus. It uses REQn/GNTn arbitration, detects master abort on a DEVSELn timeout, and returns status and read data over a valid pulse.

Parameters:
DEVSEL_TIMEOUT, 5, data-phase clocks allowed for DEVSELn assertion before master abort (1..15).
TRDY_TIMEOUT, 16, data-phase clocks allowed for TRDYn after DEVSELn before a target-timeout abort (1..255).

Ports:
CLK  input  1  PCI clock; all logic on rising edge
RSTn  input  1  asynchronous active-low reset
req_valid  input  1  request present
req_ready  output  1  request accepted when req_valid & req_ready at posedge
req_addr  input  32  transaction address
req_cmd  input  4  PCI command (0011 IO write, 0010 IO read, 0111/0110 mem write/read)
req_be  input  4  active-low byte enables for data phase
req_wdata  input  32  write data
resp_valid  output  1  one-clock completion pulse
resp_status  output  2  00 ok, 01 master abort, 10 target timeout
resp_rdata  output  32  read data; valid with resp_valid on ok reads
REQn  output  1  bus request to arbiter
GNTn  input  1  bus grant
FRAMEn  inout  1  driven while owning bus, else Z
IRDYn  inout  1  driven while owning bus, else Z
AD  inout  32  address/data
CBE  inout  4  command/byte enables
TRDYn  input  1  target ready
DEVSELn  input  1  device select

Behaviour:
- Reset: state IDLE, req_ready=1, REQn=1, resp_valid=0, resp_status=00, resp_rdata=0, all bus outputs Z, counters 0.
- Request latched at accept; req_ready=0 from the accepting edge until the cycle after resp_valid.
- Read command = req_cmd[0]==0; otherwise write.
- REQ: REQn=0. Move to ADDR on the edge where GNTn=0, FRAMEn=1 and IRDYn=1 (bus idle), all sampled.
- ADDR (1 clk): FRAMEn=0, AD=addr, CBE=cmd; IRDYn driven 1. REQn returns to 1 at the ADDR entry edge.
- DATA: FRAMEn=1 (only and last phase), IRDYn=0, CBE=be. On write, AD=wdata. On read, AD=Z and resp_rdata is captured from AD on completion. Wait counter starts at 0 and increments each DATA clock.
- Completion: DEVSELn=0 & TRDYn=0 sampled -> status 00 -> TURN. This includes the first DATA clock, which is the case for a fast-decode target that asserts DEVSELn and TRDYn together.
- Master abort: DEVSELn still 1 when counter reaches DEVSEL_TIMEOUT -> status 01 -> TURN. No data is captured.
- Target timeout: DEVSELn=0 but TRDYn=1 for TRDY_TIMEOUT clocks -> status 10 -> TURN.
- TURN (1 clk): FRAMEn=1 and IRDYn=1 driven; AD and CBE Z. Next edge: FRAMEn/IRDYn Z, resp_valid=1 for one clock, go IDLE.
- GNTn deasserted during ADDR/DATA has no effect; the transaction runs to completion (single phase).
- Reset mid-transaction: all bus signals Z immediately (asynchronous), no resp_valid issued, request discarded.
- Back-to-back: a new request is accepted the clock after resp_valid. Minimum transaction span is REQ→ADDR→DATA→TURN→resp, 5 clocks with an immediate grant.

Optional Feature:
PCI_INIT_PARITY_EN: when defined, adds output PAR (inout 1) and input PERRn.
- PAR is driven one clock after each phase in which the initiator drives AD: even parity over AD[31:0] and CBE[3:0], so the XOR of the 37 bits is 0. Otherwise PAR is Z.
- On reads, the initiator checks PAR from the target one clock after completion. A mismatch sets resp_status=11, with resp_valid delayed one clock.
- PERRn=0 sampled two clocks after a write data phase also reports status 11.
- When the macro is undefined: no PAR/PERRn ports and status 11 never occurs.

Test Plan:
1. IO write to 0x00000200, cmd 0011, wdata 0x1, with the LED target attached. GNTn low immediately -> FRAMEn low exactly 1 clk with AD=0x200, DEVSELn/TRDYn low on first DATA clock, resp_status=00, LED=1.
2. IO write to 0x00000300 (no target) -> DEVSELn never asserts, IRDYn low for 5 clocks, resp_status=01, bus Z after TURN.
3. IO read to 0x400 with a model target that inserts 3 wait states and returns 0xDEADBEEF -> AD Z during DATA, resp_rdata=0xDEADBEEF, status 00.
4. Target with DEVSELn=0 and TRDYn held high -> status 10 after 16 DATA clocks.
5. GNTn held high for 10 clocks, bus busy with FRAMEn low from another master -> REQn stays low, no bus drive until GNTn=0 and the bus is idle.
6. RSTn asserted during DATA -> FRAMEn/IRDYn/AD/CBE Z in the same cycle, no resp_valid, req_ready=1 after release.
